// File: rtl/ifetch_buf_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// Bus geometry, word-access code, FSM encoding and the FIFO entry layout.
package ifetch_buf_pkg;

  localparam int XLEN        = 32;
  localparam int BUS_WIDTH   = 32;
  localparam int BUS_ACC_CNT = 4;
  localparam int ACC_W       = $clog2(BUS_ACC_CNT);

  // Access-size code driven on m_acc: 0=byte, 1=half, 2=word.
  localparam logic [ACC_W-1:0] ACC_WORD = ACC_W'(2);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [BUS_WIDTH-1:0] instr;
    logic                 fault;
  } fetch_ent_t;

endpackage

// File: rtl/ifetch_buf_fifo.sv
// Synchronous FIFO with flush; head entry and occupancy come straight from registers.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW:0]      cnt_reg;
  logic             do_push;
  logic             do_pop;

  // When full, a push may still land in the slot the head is vacating.
  assign do_pop  = pop && (cnt_reg != '0);
  assign do_push = push && ((cnt_reg != FULL_CNT) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= din;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      cnt_reg <= cnt_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  assign dout  = mem_reg[rd_ptr_reg];
  assign valid = (cnt_reg != '0);
  assign cnt   = cnt_reg;

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch unit: sequential word fetches, one outstanding bus transaction,
// prefetch FIFO toward decode, redirect flush with stale-response draining.
module ifetch_buf
  import ifetch_buf_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 redir,
  input  logic [XLEN-1:0]      redir_pc,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [XLEN-1:0]      o_pc,
  output logic [BUS_WIDTH-1:0] o_instr,
  output logic                 o_fault,
  output logic                 m_req,
  output logic [XLEN-1:0]      m_addr,
  output logic                 m_w_rb,
  output logic [ACC_W-1:0]     m_acc,
  output logic [BUS_WIDTH-1:0] m_wdata,
  input  logic                 m_resp,
  input  logic [BUS_WIDTH-1:0] m_rdata,
  input  logic                 m_fault,
  input  logic                 bus_fault
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  state_t          state_reg, state_next;
  logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
  logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
  logic            outst_reg, outst_next;
  logic            pfault_reg, pfault_next;
  logic [CW-1:0]   cnt;
  logic            pop, old_done, old_fault, issue, new_resp, new_bf, defer, push, cap_ok;
  fetch_ent_t      push_ent, head_ent;

  assign pop       = o_valid && o_ready;
  // pfault_reg marks an outstanding slot whose bus_fault was already seen; it retires next cycle.
  assign old_done  = outst_reg && (m_resp || pfault_reg);
  assign old_fault = pfault_reg || m_fault;
  assign cap_ok    = ({1'b0, cnt} + {{CW{1'b0}}, outst_reg}) < (DEPTH_W + {{CW{1'b0}}, pop});

  assign issue = !rst && (state_reg == ST_RUN) && !redir && cap_ok &&
                 (!outst_reg || (old_done && !old_fault));
  assign new_resp = issue && !outst_reg && m_resp;
  assign new_bf   = issue && bus_fault;
  // A bus_fault on a request issued while the previous one retires cannot share the push port.
  assign defer    = new_bf && old_done;
  assign push     = !redir && (state_reg != ST_DRAIN) && (old_done || new_resp || new_bf);

  always_comb begin
    push_ent = '0;
    if (old_done) begin
      push_ent.pc    = pend_pc_reg;
      push_ent.instr = pfault_reg ? '0 : m_rdata;
      push_ent.fault = old_fault;
    end else begin
      push_ent.pc    = fetch_pc_reg;
      push_ent.instr = new_bf ? '0 : m_rdata;
      push_ent.fault = new_bf || m_fault;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    pend_pc_next  = pend_pc_reg;
    outst_next    = outst_reg;
    pfault_next   = 1'b0;
    if (redir) begin
      fetch_pc_next = redir_pc & ~XLEN'(3);
      outst_next    = outst_reg && !old_done;
      state_next    = outst_next ? ST_DRAIN : ST_RUN;
    end else begin
      if (issue) begin
        fetch_pc_next = fetch_pc_reg + XLEN'(4);
        pend_pc_next  = fetch_pc_reg;
      end
      outst_next  = (outst_reg && !old_done) || (issue && !new_resp && !new_bf) || defer;
      pfault_next = defer;
      if (state_reg == ST_DRAIN) begin
        if (old_done) state_next = ST_RUN;
      end else if (push && push_ent.fault) begin
        state_next = ST_HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      fetch_pc_reg <= RESET_PC;
      pend_pc_reg  <= '0;
      outst_reg    <= 1'b0;
      pfault_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      pend_pc_reg  <= pend_pc_next;
      outst_reg    <= outst_next;
      pfault_reg   <= pfault_next;
    end
  end

  ifetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_ent_t))
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redir),
    .push  (push),
    .din   (push_ent),
    .pop   (pop),
    .dout  (head_ent),
    .valid (o_valid),
    .cnt   (cnt)
  );

  assign o_pc    = head_ent.pc;
  assign o_instr = head_ent.instr;
  assign o_fault = head_ent.fault;
  assign m_req   = issue;
  assign m_addr  = fetch_pc_reg;
  assign m_w_rb  = 1'b0;
  assign m_acc   = ACC_WORD;
  assign m_wdata = '0;

endmodule

// File: tb/tb_ifetch_buf.sv
// Bench for ifetch_buf: procedural bus slave with selectable latency and fault regions,
// plus a decode-side stream model (expected pc sequence, redirect/reset restarts, halt on fault).
module tb_ifetch_buf;
  import ifetch_buf_pkg::*;

  localparam logic [31:0] KEY = 32'h5EED_1234;

  logic clk = 1'b0;
  logic rst, redir, o_ready, m_resp, m_fault, bus_fault;
  logic [31:0] redir_pc, m_rdata;
  logic o_valid, o_fault, m_req, m_w_rb;
  logic [31:0] o_pc, o_instr, m_addr, m_wdata;
  logic [ACC_W-1:0] m_acc;

  ifetch_buf dut (
    .clk(clk), .rst(rst), .redir(redir), .redir_pc(redir_pc),
    .o_valid(o_valid), .o_ready(o_ready), .o_pc(o_pc), .o_instr(o_instr), .o_fault(o_fault),
    .m_req(m_req), .m_addr(m_addr), .m_w_rb(m_w_rb), .m_acc(m_acc), .m_wdata(m_wdata),
    .m_resp(m_resp), .m_rdata(m_rdata), .m_fault(m_fault), .bus_fault(bus_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic rst_set = 1'b1, redir_set = 1'b0, rdy_set = 1'b0;
  logic [31:0] redir_tgt = '0;
  int lat_fix = 0;
  logic pend_v = 1'b0;
  int pend_due = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] req_q[$];
  int reqc_q[$];
  logic [31:0] exp_pc = '0;
  logic halted = 1'b0;
  int pops = 0;
  int fpops = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic is_fault_addr(input logic [31:0] a);
    return (a[31:28] == 4'h2) || (a[31:28] == 4'h4);
  endfunction

  task automatic drive_resp(input logic [31:0] a);
    m_resp  = 1'b1;
    m_rdata = a ^ KEY;
    m_fault = (a[31:28] == 4'h2);
  endtask

  // One clock cycle: apply inputs, run the slave, then sample and model the decode stream.
  task automatic step();
    int lat;
    logic efault;
    @(posedge clk);
    #1;
    cyc++;
    rst = rst_set; redir = redir_set; redir_pc = redir_tgt; o_ready = rdy_set;
    m_resp = 1'b0; m_fault = 1'b0; m_rdata = '0; bus_fault = 1'b0;
    if (rst_set) pend_v = 1'b0;
    if (pend_v && pend_due == cyc) begin
      drive_resp(pend_addr);
      pend_v = 1'b0;
    end
    #1;
    if (m_req) begin
      req_q.push_back(m_addr);
      reqc_q.push_back(cyc);
      chk("one_outst", {31'd0, pend_v}, 32'd0);
      if (m_addr[31:28] == 4'h4) begin
        bus_fault = 1'b1;
      end else begin
        lat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        if (lat == 0 && m_resp) lat = 1;
        if (lat == 0) drive_resp(m_addr);
        else begin
          pend_v = 1'b1; pend_due = cyc + lat; pend_addr = m_addr;
        end
      end
    end
    #2;
    if (!rst_set && o_valid && o_ready) begin
      efault = is_fault_addr(exp_pc);
      chk("pop_after_halt", {31'd0, halted}, 32'd0);
      chk("pop_pc", o_pc, exp_pc);
      chk("pop_fault", {31'd0, o_fault}, {31'd0, efault});
      if (!efault) chk("pop_instr", o_instr, exp_pc ^ KEY);
      if (efault) begin halted = 1'b1; fpops++; end
      exp_pc += 32'd4;
      pops++;
    end
    if (rst_set) begin exp_pc = 32'h0; halted = 1'b0; end
    else if (redir_set) begin exp_pc = redir_tgt & ~32'h3; halted = 1'b0; end
  endtask

  task automatic do_redir(input logic [31:0] tgt);
    redir_set = 1'b1; redir_tgt = tgt;
    step();
    redir_set = 1'b0;
  endtask

  task automatic do_reset();
    rst_set = 1'b1;
    step();
    step();
    rst_set = 1'b0;
  endtask

  initial begin
    int base, p0, f0, c8;
    rst = 1'b1; redir = 1'b0; redir_pc = '0; o_ready = 1'b0;
    m_resp = 1'b0; m_fault = 1'b0; m_rdata = '0; bus_fault = 1'b0;

    // Reset values
    do_reset();
    chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_m_w_rb", {31'd0, m_w_rb}, 32'd0);
    chk("rst_m_wdata", m_wdata, 32'd0);
    chk("rst_m_acc", {30'd0, m_acc}, 32'd2);
    chk("rst_o_pc", o_pc, 32'd0);
    chk("rst_o_instr", o_instr, 32'd0);
    chk("rst_o_fault", {31'd0, o_fault}, 32'd0);

    // Zero-wait slave, decode always ready: one word per cycle
    lat_fix = 0; rdy_set = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("zw_m_req", {31'd0, m_req}, 32'd1);
      chk("zw_m_addr", m_addr, 32'(4 * i));
      chk("zw_o_valid", {31'd0, o_valid}, (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) chk("zw_o_pc", o_pc, 32'(4 * (i - 1)));
    end

    // Decode stalled, latency 3: exactly two requests
    do_reset();
    req_q.delete(); reqc_q.delete();
    lat_fix = 3; rdy_set = 1'b0;
    for (int i = 0; i < 12; i++) step();
    chk("stall_nreq", 32'(req_q.size()), 32'd2);
    if (req_q.size() >= 2) begin
      chk("stall_addr0", req_q[0], 32'h0);
      chk("stall_addr1", req_q[1], 32'h4);
    end
    chk("stall_m_req", {31'd0, m_req}, 32'd0);
    chk("stall_o_valid", {31'd0, o_valid}, 32'd1);
    rdy_set = 1'b1;
    for (int i = 0; i < 10 && req_q.size() < 3; i++) step();
    chk("resume_nreq", 32'(req_q.size()), 32'd3);
    c8 = (req_q.size() >= 3) ? reqc_q[2] : 0;
    if (req_q.size() >= 3) chk("resume_addr", req_q[2], 32'h8);

    // Redirect with 0x8 outstanding: flush, drop stale response, refetch after it
    do_redir(32'h1000_0006);
    step();
    chk("redir_flush", {31'd0, o_valid}, 32'd0);
    for (int i = 0; i < 10 && req_q.size() < 4; i++) step();
    chk("redir_nreq", 32'(req_q.size()), 32'd4);
    if (req_q.size() >= 4) begin
      chk("redir_addr", req_q[3], 32'h1000_0004);
      chk("redir_cycle", 32'(reqc_q[3]), 32'(c8 + 3 + 1));
    end
    for (int i = 0; i < 6; i++) step();

    // bus_fault: faulted entry, then silence until redirect
    lat_fix = 0; rdy_set = 1'b0;
    for (int i = 0; i < 6; i++) step();
    do_redir(32'h4000_0000);
    base = req_q.size();
    step();
    chk("bf_m_req", {31'd0, m_req}, 32'd1);
    chk("bf_m_addr", m_addr, 32'h4000_0000);
    for (int i = 0; i < 4; i++) step();
    chk("bf_o_valid", {31'd0, o_valid}, 32'd1);
    chk("bf_o_fault", {31'd0, o_fault}, 32'd1);
    chk("bf_o_pc", o_pc, 32'h4000_0000);
    chk("bf_nreq", 32'(req_q.size()), 32'(base + 1));
    rdy_set = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("bf_drained", {31'd0, o_valid}, 32'd0);
    chk("bf_halt_nreq", 32'(req_q.size()), 32'(base + 1));
    rdy_set = 1'b0;
    do_redir(32'h0);
    step();
    chk("bf_restart_req", {31'd0, m_req}, 32'd1);
    chk("bf_restart_addr", m_addr, 32'h0);

    // m_fault at 0x20000000 delivered after good entries, then HALT
    lat_fix = -1; rdy_set = 1'b1;
    do_redir(32'h1FFF_FFF8);
    p0 = pops; f0 = fpops;
    for (int i = 0; i < 60 && pops < p0 + 3; i++) step();
    for (int i = 0; i < 8; i++) step();
    chk("mf_pops", 32'(pops - p0), 32'd3);
    chk("mf_fault_pops", 32'(fpops - f0), 32'd1);
    chk("mf_last_req", req_q[$], 32'h2000_0000);
    chk("mf_halt_valid", {31'd0, o_valid}, 32'd0);

    // Address wrap
    base = req_q.size();
    do_redir(32'hFFFF_FFFE);
    for (int i = 0; i < 20 && req_q.size() < base + 2; i++) step();
    chk("wrap_nreq_ok", {31'd0, req_q.size() >= base + 2}, 32'd1);
    if (req_q.size() >= base + 2) begin
      chk("wrap_addr0", req_q[base], 32'hFFFF_FFFC);
      chk("wrap_addr1", req_q[base + 1], 32'h0000_0000);
    end

    // Randomized traffic: ready, latency, redirects, one mid-run reset
    p0 = pops;
    for (int i = 0; i < 800; i++) begin
      rdy_set = ($urandom_range(0, 3) != 0);
      if (i == 400) rst_set = 1'b1;
      if (i == 402) rst_set = 1'b0;
      if (!rst_set && $urandom_range(0, 29) == 0) begin
        redir_set = 1'b1;
        redir_tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 32'h0000_FFFF));
      end
      step();
      redir_set = 1'b0;
    end
    chk("rand_progress", {31'd0, (pops - p0) >= 100}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
